// File: rtl/const_mul_sub_pkg.sv
// Shared helpers for the constant multiply/subtract pipeline.
// Saturation is enabled with CONST_MUL_SUB_SAT_EN.
package const_mul_sub_pkg;

   localparam int K_MIN    = 0;
   localparam int K_MAX    = 255;
   localparam int IN_W_MIN = 2;
   localparam int MAX_W    = 128;

   typedef logic signed [MAX_W-1:0] wide_t;

   typedef struct packed {
      logic  sat;
      wide_t val;
   } sat_res_t;

   function automatic int int_w(input int in_w);
      return in_w + 10;
   endfunction

   function automatic sat_res_t sat_to_width(input wide_t v,
                                             input int    ow);
      sat_res_t r;
      wide_t    hi;
      wide_t    lo;
      hi    = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
      lo    = -hi - wide_t'(1);
      r.sat = 1'b0;
      r.val = v;
      if (v > hi) begin
         r.sat = 1'b1;
         r.val = hi;
      end else if (v < lo) begin
         r.sat = 1'b1;
         r.val = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/const_mul_sub_pipe_shift_add_const.sv
// Combinational K*x built from shifted copies of x.
// One adder term per set bit of the 8-bit constant.
module shift_add_const
   import const_mul_sub_pkg::*;
#(
   parameter int IN_W  = 33,
   parameter int INT_W = 43,
   parameter int K     = 13
) (
   input  logic signed [IN_W-1:0]  x_i,
   output logic signed [INT_W-1:0] p_o
);

   localparam logic [7:0] KB = 8'(K);

   logic signed [INT_W-1:0] xe;
   logic signed [INT_W-1:0] sum [9];

   assign xe     = INT_W'(x_i);
   assign sum[0] = '0;

   for (genvar i = 0; i < 8; i++) begin : g_bit
      if (KB[i]) begin : g_on
         assign sum[i+1] = sum[i] + (xe <<< i);
      end else begin : g_off
         assign sum[i+1] = sum[i];
      end
   end

   assign p_o = sum[8];

endmodule

// File: rtl/const_mul_sub_pipe.sv
// Two-stage K_MUL*x and b-K_SUB*x pipeline with valid/ready.
// Optional clamping via CONST_MUL_SUB_SAT_EN.
module const_mul_sub_pipe
   import const_mul_sub_pkg::*;
#(
   parameter int IN_W  = 33,
   parameter int OUT_W = 37,
   parameter int K_MUL = 13,
   parameter int K_SUB = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  x_i,
   input  logic signed [IN_W-1:0]  b_i,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] mul_o,
   output logic signed [OUT_W-1:0] minus_o,
   output logic                    sat_o
);

   localparam int INT_W = int_w(IN_W);

   if (K_MUL < K_MIN || K_MUL > K_MAX ||
       K_SUB < K_MIN || K_SUB > K_MAX ||
       IN_W < IN_W_MIN || OUT_W > MAX_W ||
       INT_W > MAX_W) begin : g_param_err
      $error("const_mul_sub_pipe: parameter out of range");
   end

   logic s1_valid_q, s1_valid_d;
   logic s2_valid_q, s2_valid_d;
   logic s1_load, s2_load;

   logic signed [INT_W-1:0] px_q, px_d;
   logic signed [INT_W-1:0] qx_q, qx_d;
   logic signed [INT_W-1:0] b_q, b_d;
   logic signed [INT_W-1:0] diff;

   logic signed [OUT_W-1:0] mul_q, mul_d;
   logic signed [OUT_W-1:0] minus_q, minus_d;

   assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
   assign in_ready = !s1_valid_q || s2_load;
   assign s1_load  = in_valid && in_ready;

   assign s1_valid_d = s1_load ? 1'b1 :
                       (s2_load ? 1'b0 : s1_valid_q);
   assign s2_valid_d = s2_load ? 1'b1 :
                       (out_ready ? 1'b0 : s2_valid_q);

   shift_add_const #(
      .IN_W  (IN_W),
      .INT_W (INT_W),
      .K     (K_MUL)
   ) u_mul (
      .x_i (x_i),
      .p_o (px_d)
   );

   shift_add_const #(
      .IN_W  (IN_W),
      .INT_W (INT_W),
      .K     (K_SUB)
   ) u_sub (
      .x_i (x_i),
      .p_o (qx_d)
   );

   assign b_d  = INT_W'(b_i);
   assign diff = b_q - qx_q;

`ifdef CONST_MUL_SUB_SAT_EN
   sat_res_t mul_r, min_r;
   logic     sat_q, sat_d;

   always_comb begin
      mul_r = sat_to_width(wide_t'(px_q), OUT_W);
      min_r = sat_to_width(wide_t'(diff), OUT_W);
   end

   assign mul_d   = OUT_W'(mul_r.val);
   assign minus_d = OUT_W'(min_r.val);
   assign sat_d   = mul_r.sat | min_r.sat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_q <= 1'b0;
      end else if (s2_load) begin
         sat_q <= sat_d;
      end
   end

   assign sat_o = sat_q;
`else
   // Wrap: keep the two's-complement low OUT_W bits.
   assign mul_d   = OUT_W'(px_q);
   assign minus_d = OUT_W'(diff);
   assign sat_o   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         px_q       <= '0;
         qx_q       <= '0;
         b_q        <= '0;
         mul_q      <= '0;
         minus_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (s1_load) begin
            px_q <= px_d;
            qx_q <= qx_d;
            b_q  <= b_d;
         end
         if (s2_load) begin
            mul_q   <= mul_d;
            minus_q <= minus_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign mul_o     = mul_q;
   assign minus_o   = minus_q;

endmodule

// File: tb/tb_const_mul_sub_pipe.sv
// Randomised and directed bench for const_mul_sub_pipe.
// Three instances share stimulus: default, OUT_W=36, K_MUL=0/K_SUB=255.
module tb_const_mul_sub_pipe;

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic in_valid  = 1'b0;
   logic out_ready = 1'b0;
   logic signed [32:0] x = '0;
   logic signed [32:0] b = '0;

   logic rdy0, rdy1, rdy2;
   logic ov0, ov1, ov2;
   logic st0, st1, st2;
   logic signed [36:0] m0, n0, m2, n2;
   logic signed [35:0] m1, n1;

   int     n_cmp = 0;
   int     n_bad = 0;
   longint ncyc  = 0;

   typedef struct {
      longint x;
      longint b;
      longint t;
   } beat_t;

   beat_t  q[$];
   bit     hold = 1'b0;
   longint hm, hn;

   always #5 clk = ~clk;

   const_mul_sub_pipe u_d0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
      .x_i(x), .b_i(b), .out_valid(ov0), .out_ready(out_ready),
      .mul_o(m0), .minus_o(n0), .sat_o(st0)
   );

   const_mul_sub_pipe #(.OUT_W(36)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
      .x_i(x), .b_i(b), .out_valid(ov1), .out_ready(out_ready),
      .mul_o(m1), .minus_o(n1), .sat_o(st1)
   );

   const_mul_sub_pipe #(.K_MUL(0), .K_SUB(255)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
      .x_i(x), .b_i(b), .out_valid(ov2), .out_ready(out_ready),
      .mul_o(m2), .minus_o(n2), .sat_o(st2)
   );

   task automatic chk(input string tag, input longint got,
                      input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint red(input longint v, input int ow,
                                  output bit s);
      longint hi, lo;
      hi = (64'sd1 <<< (ow - 1)) - 1;
      lo = -hi - 1;
      s  = 1'b0;
`ifdef CONST_MUL_SUB_SAT_EN
      if (v > hi) begin
         s = 1'b1;
         return hi;
      end
      if (v < lo) begin
         s = 1'b1;
         return lo;
      end
      return v;
`else
      return (v <<< (64 - ow)) >>> (64 - ow);
`endif
   endfunction

   function automatic longint rnd33();
      logic [32:0] r;
      r = {1'($urandom_range(0, 1)), 32'($urandom)};
      return longint'($signed(r));
   endfunction

   task automatic chk_inst(input string tag, input longint km,
                           input longint ks, input int ow,
                           input longint gm, input longint gn,
                           input logic gs, input beat_t bt);
      bit     sm, sn;
      longint em, en;
      em = red(km * bt.x, ow, sm);
      en = red(bt.b - ks * bt.x, ow, sn);
      chk({tag, "_mul"}, gm, em);
      chk({tag, "_minus"}, gn, en);
      chk({tag, "_sat"}, longint'(gs), longint'(sm | sn));
   endtask

   task automatic cycle(input logic iv, input longint xv,
                        input longint bv, input logic ordy,
                        output bit acc);
      bit exp_ov;
      @(negedge clk);
      in_valid  = iv;
      x         = 33'(xv);
      b         = 33'(bv);
      out_ready = ordy;
      #1;
      chk("in_ready", longint'(rdy0),
          longint'((q.size() < 2) || ordy));
      exp_ov = (q.size() > 0) && (ncyc >= q[0].t + 2);
      chk("out_valid", longint'(ov0), longint'(exp_ov));
      if (hold) begin
         chk("stall_mul", m0, hm);
         chk("stall_minus", n0, hn);
      end
      if (ov0 && q.size() > 0) begin
         chk_inst("d0", 13, 6, 37, m0, n0, st0, q[0]);
         chk_inst("d1", 13, 6, 36, m1, n1, st1, q[0]);
         chk_inst("d2", 0, 255, 37, m2, n2, st2, q[0]);
      end
      hold = ov0 && !ordy;
      hm   = m0;
      hn   = n0;
      if (ov0 && ordy && q.size() > 0) void'(q.pop_front());
      acc = iv && rdy0;
      if (acc) q.push_back('{xv, bv, ncyc});
      @(posedge clk);
      ncyc++;
   endtask

   task automatic directed(input longint xv, input longint bv);
      bit a;
      cycle(1'b1, xv, bv, 1'b1, a);
      chk("dir_accept", longint'(a), 1);
      cycle(1'b0, 0, 0, 1'b1, a);
      #1;
      chk("dir_valid", longint'(ov0), 1);
   endtask

   initial begin
      bit a;
      int idx;
      int c;

      #12;
      chk("rst_valid", longint'(ov0), 0);
      chk("rst_ready", longint'(rdy0), 1);
      chk("rst_mul", m0, 0);
      chk("rst_minus", n0, 0);
      chk("rst_sat", longint'(st0), 0);
      @(negedge clk);
      rst = 1'b0;

      directed(1, 10);
      chk("basic_mul", m0, 13);
      chk("basic_minus", n0, 4);
      chk("basic_sat", longint'(st0), 0);
      cycle(1'b0, 0, 0, 1'b1, a);

      directed(-64'sd4294967296, 0);
      chk("ext_mul", m0, -64'sd55834574848);
      chk("ext_minus", n0, 64'sd25769803776);
      chk("ext_sat", longint'(st0), 0);
      cycle(1'b0, 0, 0, 1'b1, a);

      directed(64'sd4294967295, 0);
`ifdef CONST_MUL_SUB_SAT_EN
      chk("sat_mul", m1, 64'sd34359738367);
      chk("sat_flag", longint'(st1), 1);
`else
      chk("wrap_mul", m1, -64'sd12884901901);
      chk("wrap_flag", longint'(st1), 0);
`endif
      cycle(1'b0, 0, 0, 1'b1, a);

      directed(3, 0);
      chk("k0_mul", m2, 0);
      chk("k255_minus", n2, -765);
      cycle(1'b0, 0, 0, 1'b1, a);

      idx = 0;
      c   = 0;
      while ((idx < 20 || q.size() > 0) && c < 200) begin
         cycle(idx < 20, longint'(idx), 100, !(c >= 5 && c <= 8), a);
         if (a) idx++;
         c++;
      end
      chk("stream_drained", longint'(c < 200), 1);
      chk("stream_count", idx, 20);

      for (int i = 0; i < 300; i++) begin
         cycle(1'($urandom_range(0, 1)), rnd33(), rnd33(),
               1'($urandom_range(0, 3) != 0), a);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 0, 0, 1'b1, a);
      chk("rand_drained", q.size(), 0);

      cycle(1'b1, 5, 7, 1'b0, a);
      cycle(1'b1, 6, 8, 1'b0, a);
      cycle(1'b1, 9, 9, 1'b0, a);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("mid_rst_valid", longint'(ov0), 0);
      chk("mid_rst_ready", longint'(rdy0), 1);
      chk("mid_rst_mul", m0, 0);
      q.delete();
      hold = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) cycle(1'b0, 0, 0, 1'b1, a);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
